// File: rtl/mem_ctrl_nch.sv
// mem_ctrl_nch: N-channel round-robin front end for the byte-serial RAM/IO port.
// Serialises 1/2/4-byte little-endian accesses, stalls IO writes while the UART
// is full, and drops speculative reads when a mispredict flush arrives.
module mem_ctrl_nch #(
  parameter int              N_CH       = 2,
  parameter logic [N_CH-1:0] FLUSH_MASK = 2'b10,
  parameter int              IO_GAP     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 jp_wrong,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH-1:0]      we,
  input  logic [2*N_CH-1:0]    size,
  input  logic [32*N_CH-1:0]   addr,
  input  logic [32*N_CH-1:0]   wdata,
  output logic [N_CH-1:0]      done,
  output logic [31:0]          rdata,
  input  logic                 io_buffer_full,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [31:0]          mem_a,
  output logic                 mem_wr
);

  localparam int RR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   g_q, g_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [1:0]        gap_q, gap_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;

  logic [N_CH-1:0]   elig;
  logic              found;
  logic [RR_W-1:0]   win;
  int                arb_idx;
  logic              io_c;
  logic              stall_c;
  logic [2:0]        rd_idx;

  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      2'd0:    byte_count = 3'd1;
      2'd1:    byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    is_io = (a[17:16] == 2'b11);
  endfunction

  // A channel whose done is showing is skipped so a held req is not re-served;
  // speculative reads are skipped while a flush is present.
  assign elig    = req & ~done_q & ~({N_CH{jp_wrong}} & FLUSH_MASK & ~we);
  assign io_c    = is_io(addr_q);
  assign stall_c = (state_q == S_WRITE) && io_c && io_buffer_full;

  // Round-robin search starting at rr_q for the first eligible channel.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = 0;
    for (int j = 0; j < N_CH; j++) begin
      arb_idx = int'(rr_q) + j;
      if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
      if (!found && elig[arb_idx]) begin
        found = 1'b1;
        win   = RR_W'(arb_idx);
      end
    end
  end

  // Control state register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      n_q     <= 3'd1;
      k_q     <= '0;
      gap_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      n_q     <= n_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request payload and read assembly buffer; only consumed after a grant.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    buf_q   <= buf_d;
  end

  // Next-state and datapath updates; everything holds while rdy is low.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    n_d     = n_q;
    k_d     = k_q;
    gap_d   = gap_q;
    done_d  = done_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    if (rdy) begin
      done_d = '0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            g_d     = win;
            rr_d    = (win == RR_W'(N_CH - 1)) ? '0 : win + RR_W'(1);
            addr_d  = addr[32*win +: 32];
            wdata_d = wdata[32*win +: 32];
            n_d     = byte_count(size[2*win +: 2]);
            k_d     = '0;
            buf_d   = '0;
            state_d = we[win] ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (jp_wrong && FLUSH_MASK[g_q]) begin
            state_d = S_IDLE;
          end else begin
            // mem_din carries the byte issued in the previous active cycle.
            if (k_q != 3'd0) buf_d[8*(int'(k_q)-1) +: 8] = mem_din;
            if (k_q == n_q) begin
              rdata_d     = buf_d;
              done_d[g_q] = 1'b1;
              state_d     = S_IDLE;
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        S_WRITE: begin
          if (!stall_c) begin
            if (k_q == 3'(n_q - 3'd1)) begin
              done_d[g_q] = 1'b1;
              gap_d       = 2'((IO_GAP > 0) ? IO_GAP - 1 : 0);
              state_d     = (io_c && IO_GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 2'd0) state_d = S_IDLE;
          else               gap_d   = gap_q - 2'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // While paused mid-read, re-present the last issued address so mem_din
  // still carries the pending byte when rdy returns.
  assign rd_idx = (rdy || k_q == 3'd0) ? k_q : k_q - 3'd1;

  // Port outputs decoded from the current state.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    case (state_q)
      S_READ: begin
        if (!(rdy && k_q == n_q)) mem_a = addr_q + 32'(rd_idx);
      end
      S_WRITE: begin
        if (!stall_c) begin
          mem_a    = addr_q + 32'(k_q);
          mem_dout = wdata_q[8*k_q +: 8];
          mem_wr   = rdy;
        end
      end
      default: ;
    endcase
  end

  assign done  = rdy ? done_q : '0;
  assign rdata = rdata_q;

endmodule
